// File: rtl/minrv32_mem_pkg.sv
// Shared types and helpers for the minrv32 memory responder.
// Contents: responder state enum, latency counter width, wstrb-to-bit-mask expansion.
package minrv32_mem_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Expand a 4-bit byte strobe into a 32-bit bit mask.
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/minrv32_mem_bytewrite.sv
// Single-port byte-write RAM used as backing store for the memory responder.
// Ports:
//   clk, rst_n      clock / async active-low reset (read register only)
//   addr            word index
//   rd_en           issue a read; data appears on rdata the next cycle
//   wr_be           per-byte write enables (write when non-zero)
//   wdata           write data
//   rdata           registered read data, 0 when no read was issued
module minrv32_ram_bytewrite
  import minrv32_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned IDX_W     = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] addr,
  input  logic             rd_en,
  input  logic [3:0]       wr_be,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] wmask;
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;

  assign wmask   = strb_to_mask(wr_be);
  // Read register clears when idle so the bus sees 0 outside a read response.
  assign rdata_d = rd_en ? mem_q[addr] : 32'h0;

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (|wr_be) begin
      mem_q[addr] <= (mem_q[addr] & ~wmask) | (wdata & wmask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/minrv32_ram_bytewrite.sv
// Intentionally empty: minrv32_ram_bytewrite is defined in minrv32_mem_bytewrite.sv.

// File: rtl/minrv32_mem_responder.sv
// Word-addressed memory slave on the minrv32 native bus with fixed response
// latency, sticky out-of-range / protocol-violation flags and txn counters.
// Ports:
//   clk, resetn                       clock / async active-low reset
//   mem_valid, mem_instr, mem_addr,   core request
//   mem_wdata, mem_wstrb
//   mem_ready, mem_rdata              one-cycle response strobe and read data
//   bus_err, proto_err                sticky error flags
//   txn_count, ifetch_count           completed transaction counters
module minrv32_mem_responder
  import minrv32_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic        proto_err,
  output logic [31:0] txn_count,
  output logic [31:0] ifetch_count
);

  localparam int unsigned   IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic               instr_q, instr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               inrange_q, inrange_d;
  logic               ready_q, ready_d;
  logic               bus_err_q, bus_err_d;
  logic               proto_err_q, proto_err_d;
  logic [31:0]        txn_q, txn_d;
  logic [31:0]        ifetch_q, ifetch_d;

  logic [31:0]        off_c;
  logic [31:0]        word_c;
  logic               inrange_c;
  logic [IDX_W-1:0]   ram_addr;
  logic               ram_rd_en;
  logic [3:0]         ram_be;
  logic [31:0]        ram_rdata;

  // Unsigned wrap makes addresses below ADDR_BASE land far out of range.
  assign off_c     = mem_addr - ADDR_BASE;
  assign word_c    = off_c >> 2;
  assign inrange_c = (word_c < 32'(MEM_WORDS));

  // Next-state, latching and response bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    instr_d     = instr_q;
    idx_d       = idx_q;
    inrange_d   = inrange_q;
    bus_err_d   = bus_err_q;
    proto_err_d = proto_err_q;
    txn_d       = txn_q;
    ifetch_d    = ifetch_q;
    ready_d     = 1'b0;
    ram_addr    = idx_q;
    ram_rd_en   = 1'b0;
    ram_be      = 4'h0;

    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          addr_d    = mem_addr;
          wdata_d   = mem_wdata;
          wstrb_d   = mem_wstrb;
          instr_d   = mem_instr;
          idx_d     = word_c[IDX_W-1:0];
          inrange_d = inrange_c;
          cnt_d     = LAT_M1;
          ram_addr  = word_c[IDX_W-1:0];
          state_d   = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!mem_valid) begin
          proto_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          if ((mem_addr != addr_q) || (mem_wstrb != wstrb_q) || (mem_wdata != wdata_q)) begin
            proto_err_d = 1'b1;
          end
          if (cnt_q == CNT_W'(1)) begin
            state_d = RESP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      RESP: begin
        if (inrange_q) begin
          ram_be = wstrb_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Entering RESP: read issued now lands in RESP; flags/counters show with ready.
    if (state_d == RESP) begin
      ready_d   = 1'b1;
      ram_rd_en = inrange_d && (wstrb_d == 4'h0);
      if (!inrange_d) begin
        bus_err_d = 1'b1;
      end
      txn_d = txn_q + 32'd1;
      if (instr_d) begin
        ifetch_d = ifetch_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      instr_q     <= 1'b0;
      idx_q       <= '0;
      inrange_q   <= 1'b0;
      ready_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
      txn_q       <= '0;
      ifetch_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      instr_q     <= instr_d;
      idx_q       <= idx_d;
      inrange_q   <= inrange_d;
      ready_q     <= ready_d;
      bus_err_q   <= bus_err_d;
      proto_err_q <= proto_err_d;
      txn_q       <= txn_d;
      ifetch_q    <= ifetch_d;
    end
  end

  minrv32_ram_bytewrite #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (resetn),
    .addr  (ram_addr),
    .rd_en (ram_rd_en),
    .wr_be (ram_be),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign mem_ready    = ready_q;
  assign mem_rdata    = ram_rdata;
  assign bus_err      = bus_err_q;
  assign proto_err    = proto_err_q;
  assign txn_count    = txn_q;
  assign ifetch_count = ifetch_q;

endmodule

// File: tb/tb_minrv32_mem_responder.sv
// Bench for minrv32_mem_responder: one instance at LATENCY=2, one at LATENCY=1,
// sharing address/data inputs with separate mem_valid. Expected read data is
// pushed to a per-instance queue when a request is driven and popped on mem_ready.
module tb_minrv32_mem_responder;

  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned LAT0      = 2;
  localparam int unsigned LAT1      = 1;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  mv;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  rdy;
  logic [1:0]  berr;
  logic [1:0]  perr;
  logic [31:0] rdata [2];
  logic [31:0] txn [2];
  logic [31:0] ifc [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [31:0] model [2][MEM_WORDS];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  logic [31:0] exp_txn [2];
  logic [31:0] exp_if [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  minrv32_mem_responder #(
    .MEM_WORDS (MEM_WORDS),
    .ADDR_BASE (32'h0000_0000),
    .LATENCY   (LAT0)
  ) u_dut_l2 (
    .clk          (clk),
    .resetn       (resetn),
    .mem_valid    (mv[0]),
    .mem_instr    (mem_instr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ready    (rdy[0]),
    .mem_rdata    (rdata[0]),
    .bus_err      (berr[0]),
    .proto_err    (perr[0]),
    .txn_count    (txn[0]),
    .ifetch_count (ifc[0])
  );

  minrv32_mem_responder #(
    .MEM_WORDS (MEM_WORDS),
    .ADDR_BASE (32'h0000_0000),
    .LATENCY   (LAT1)
  ) u_dut_l1 (
    .clk          (clk),
    .resetn       (resetn),
    .mem_valid    (mv[1]),
    .mem_instr    (mem_instr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ready    (rdy[1]),
    .mem_rdata    (rdata[1]),
    .bus_err      (berr[1]),
    .proto_err    (perr[1]),
    .txn_count    (txn[1]),
    .ifetch_count (ifc[1])
  );

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Response monitor: every ready pops one expected value; rdata is 0 otherwise.
  always @(negedge clk) begin
    if (resetn) begin
      if (rdy[0]) begin
        if (exp_q0.size() == 0) check32("l2_unexpected_ready", {31'b0, rdy[0]}, 32'h0);
        else                    check32("l2_rdata", rdata[0], exp_q0.pop_front());
      end else begin
        check32("l2_rdata_idle", rdata[0], 32'h0);
      end
      if (rdy[1]) begin
        if (exp_q1.size() == 0) check32("l1_unexpected_ready", {31'b0, rdy[1]}, 32'h0);
        else                    check32("l1_rdata", rdata[1], exp_q1.pop_front());
      end else begin
        check32("l1_rdata_idle", rdata[1], 32'h0);
      end
    end
  end

  // One complete transaction; called with time just after a posedge, DUT idle.
  task automatic do_txn(input int sel, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic instr, output int rcyc);
    logic [31:0] word;
    logic [31:0] expv;
    int          n;
    word = addr >> 2;
    expv = 32'h0;
    if (word < 32'(MEM_WORDS)) begin
      if (wstrb == 4'h0) begin
        expv = model[sel][word[9:0]];
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (wstrb[i]) model[sel][word[9:0]][8*i +: 8] = wdata[8*i +: 8];
        end
      end
    end
    if (sel == 0) exp_q0.push_back(expv);
    else          exp_q1.push_back(expv);
    exp_txn[sel] = exp_txn[sel] + 32'd1;
    if (instr) exp_if[sel] = exp_if[sel] + 32'd1;

    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    mem_instr = instr;
    mv[sel]   = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[sel] && n < 20);
    rcyc = cyc;
    check32($sformatf("latency_dut%0d", sel), 32'(n), (sel == 0) ? 32'(LAT0) : 32'(LAT1));
    @(posedge clk);
    #1;
    mv[sel] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int rc;
    int prev_rc;
    resetn    = 1'b0;
    mv        = 2'b00;
    mem_instr = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    exp_txn   = '{32'h0, 32'h0};
    exp_if    = '{32'h0, 32'h0};

    repeat (3) @(posedge clk);
    #1;
    check32("rst_ready", {30'b0, rdy}, 32'h0);
    check32("rst_rdata0", rdata[0], 32'h0);
    check32("rst_rdata1", rdata[1], 32'h0);
    check32("rst_errs", {28'b0, berr, perr}, 32'h0);
    check32("rst_txn0", txn[0], 32'h0);
    check32("rst_ifc0", ifc[0], 32'h0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Preload through the bus, then read back.
    do_txn(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, rc);
    do_txn(0, 32'h20, 32'hAAAA_AAAA, 4'hF, 1'b0, rc);
    do_txn(0, 32'h30, 32'h5555_AAAA, 4'hF, 1'b0, rc);
    do_txn(0, 32'h00, 32'h0123_4567, 4'hF, 1'b0, rc);
    do_txn(0, 32'h10, 32'h0, 4'h0, 1'b0, rc);
    check32("txn_after_preload", txn[0], exp_txn[0]);

    // Partial store then read-after-write.
    do_txn(0, 32'h20, 32'h1122_3344, 4'b0101, 1'b0, rc);
    do_txn(0, 32'h20, 32'h0, 4'h0, 1'b0, rc);
    do_txn(0, 32'h10, 32'h0000_00CC, 4'b1000, 1'b0, rc);
    do_txn(0, 32'h10, 32'h0, 4'h0, 1'b1, rc);
    check32("txn_after_rmw", txn[0], exp_txn[0]);
    check32("ifc_after_rmw", ifc[0], exp_if[0]);
    check32("no_bus_err_yet", {31'b0, berr[0]}, 32'h0);

    // Out-of-range store: responds with 0, sets bus_err, leaves RAM[0] alone.
    do_txn(0, 32'h1000, 32'hFFFF_FFFF, 4'hF, 1'b0, rc);
    check32("bus_err_set", {31'b0, berr[0]}, 32'h1);
    do_txn(0, 32'h00, 32'h0, 4'h0, 1'b0, rc);
    check32("bus_err_sticky", {31'b0, berr[0]}, 32'h1);

    // Drop valid one cycle into WAIT.
    mem_addr  = 32'h10;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    mem_instr = 1'b0;
    mv[0]     = 1'b1;
    @(posedge clk);
    #1;
    mv[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check32("abort_no_ready", {31'b0, rdy[0]}, 32'h0);
    end
    check32("proto_err_set", {31'b0, perr[0]}, 32'h1);
    check32("abort_txn_unchanged", txn[0], exp_txn[0]);
    @(posedge clk);
    #1;
    do_txn(0, 32'h10, 32'h0, 4'h0, 1'b0, rc);
    check32("proto_err_sticky", {31'b0, perr[0]}, 32'h1);
    check32("txn_after_abort", txn[0], exp_txn[0]);

    // LATENCY=1 instance: preload, then back-to-back fetches.
    for (int i = 0; i < 5; i++) begin
      do_txn(1, 32'(4 * i), 32'hC0DE_0000 + 32'(i * 17), 4'hF, 1'b0, rc);
    end
    prev_rc = 0;
    for (int i = 0; i < 5; i++) begin
      do_txn(1, 32'(4 * i), 32'h0, 4'h0, 1'b1, rc);
      if (i > 0) check32("b2b_spacing", 32'(rc - prev_rc), 32'd2);
      prev_rc = rc;
    end
    check32("l1_ifetch_count", ifc[1], exp_if[1]);
    check32("l1_txn_count", txn[1], exp_txn[1]);
    check32("l1_no_errs", {30'b0, berr[1], perr[1]}, 32'h0);

    // Reset in the middle of a pending store to 0x30.
    mem_addr  = 32'h30;
    mem_wdata = 32'hFFFF_FFFF;
    mem_wstrb = 4'hF;
    mem_instr = 1'b0;
    mv[0]     = 1'b1;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check32("rst_mid_ready", {31'b0, rdy[0]}, 32'h0);
    check32("rst_mid_txn0", txn[0], 32'h0);
    check32("rst_mid_ifc1", ifc[1], 32'h0);
    check32("rst_mid_errs", {28'b0, berr, perr}, 32'h0);
    mv[0]   = 1'b0;
    exp_txn = '{32'h0, 32'h0};
    exp_if  = '{32'h0, 32'h0};
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    do_txn(0, 32'h30, 32'h0, 4'h0, 1'b0, rc);
    check32("txn_after_reset", txn[0], exp_txn[0]);
    repeat (2) @(posedge clk);
    check32("queue_drained", 32'(exp_q0.size() + exp_q1.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
